// File: rtl/seq_sm_mul.sv
// Sequential shift-add multiplier for sign-magnitude or unsigned operands.
// Each operation retires one multiplier bit per cycle, then spends one cycle applying the sign.
module seq_sm_mul #(
  parameter int WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   out,
  output logic [1:0]           dbg_state
);

  // Handshake: start is taken only while busy=0 (IDLE, including the done cycle);
  // a, b and mode are captured on that edge, and done pulses once when out updates.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam int                CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]     CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
  localparam logic [2*WIDTH-1:0] ACC_ONE = (2*WIDTH)'(1);

  state_t                 state;
  state_t                 state_nxt;
  logic [WIDTH-1:0]       mcand;
  logic [WIDTH-1:0]       mplier;
  logic [2*WIDTH-1:0]     acc;
  logic [CW-1:0]          cnt;
  logic                   sign;
  logic [WIDTH-1:0]       mag_a;
  logic [WIDTH-1:0]       mag_b;
  logic [2*WIDTH-1:0]     partial;

  // In sign-magnitude mode the MSB is stripped here and carried separately as the sign.
  always_comb begin
    mag_a   = mode ? a : {1'b0, a[WIDTH-2:0]};
    mag_b   = mode ? b : {1'b0, b[WIDTH-2:0]};
    partial = {{WIDTH{1'b0}}, mcand} << cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == CNT_LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      sign   <= 1'b0;
      out    <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= mag_a;
            mplier <= mag_b;
            sign   <= ~mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          if (mplier[0]) acc <= acc + partial;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_ONE;
        end
        FIX: begin
          // Negating a zero magnitude yields zero, so negative zero never reaches out.
          out  <= sign ? (~acc + ACC_ONE) : acc;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_seq_sm_mul.sv
// Bench for seq_sm_mul: directed cases, handshake corners, reset mid-operation,
// an exhaustive sign-magnitude sweep and random mixed-mode operations.
module tb_seq_sm_mul;
  localparam int W = 6;

  logic            clk;
  logic            rst;
  logic            start;
  logic            mode;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic            busy;
  logic            done;
  logic [2*W-1:0]  out;
  logic [1:0]      dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  logic [2*W-1:0] exp_q[$];
  int             m_cnt  = 0;
  logic           m_done = 1'b0;
  logic [2*W-1:0] m_out  = '0;

  seq_sm_mul #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
    .busy(busy), .done(done), .out(out), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference: plain arithmetic on the operand values
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic md);
    int mx;
    int my;
    int p;
    if (md) begin
      p = int'(x) * int'(y);
    end else begin
      mx = int'(x) % (1 << (W - 1));
      my = int'(y) % (1 << (W - 1));
      p  = mx * my;
      if (x[W-1] != y[W-1]) p = -p;
    end
    return (2*W)'(p);
  endfunction

  function automatic logic [W-1:0] sm_enc(input int v);
    logic [W-1:0] r;
    if (v < 0) begin
      r = W'(-v);
      r[W-1] = 1'b1;
    end else begin
      r = W'(v);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // timing model: an accepted start keeps the unit busy for W+1 edges, then done pulses
  always @(posedge clk) begin
    if (rst) begin
      m_cnt  = 0;
      m_done = 1'b0;
      m_out  = '0;
      exp_q.delete();
    end else begin
      m_done = (m_cnt == 1);
      if (m_cnt > 0) m_cnt = m_cnt - 1;
      else if (start === 1'b1) begin
        exp_q.push_back(ref_mul(a, b, mode));
        m_cnt = W + 1;
      end
    end
  end

  // monitor: pops on every done and checks busy/done/out each cycle
  always @(negedge clk) begin
    check("busy", {{(2*W-1){1'b0}}, busy}, {{(2*W-1){1'b0}}, (m_cnt != 0)});
    check("done", {{(2*W-1){1'b0}}, done}, {{(2*W-1){1'b0}}, m_done});
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL product: done with no expected result, out=%h at %0t", out, $time);
      end else begin
        m_out = exp_q.pop_front();
      end
    end
    check("out", out, m_out);
  end

  // driver tasks
  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic md);
    @(negedge clk);
    start = 1'b1; a = x; b = y; mode = md;
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom); mode = 1'($urandom);
    repeat (W) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    op(6'b100011, 6'b000101, 1'b0);
    op(6'b011111, 6'b111111, 1'b0);
    op(6'b111111, 6'b111111, 1'b0);
    op(6'd63, 6'd63, 1'b1);
    op(6'd63, 6'd63, 1'b0);
    op(6'b100000, 6'b000111, 1'b0);
    op(6'b100101, 6'b100000, 1'b0);
    op(6'b000000, 6'b111111, 1'b1);

    // start held high with operands changing every cycle
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a = W'($urandom); b = W'($urandom); mode = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (W + 2) @(negedge clk);

    // reset during CALC, then a fresh operation
    @(negedge clk);
    start = 1'b1; a = 6'b010101; b = 6'b001011; mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    op(6'b110101, 6'b001011, 1'b0);

    for (int x = -31; x <= 31; x++)
      for (int y = -31; y <= 31; y++)
        op(sm_enc(x), sm_enc(y), 1'b0);

    for (int i = 0; i < 300; i++)
      op(W'($urandom_range(0, 63)), W'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));

    repeat (W + 3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d results never produced", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
